jtcps1_main_busreq: RTL

Front end of the 68000 main-bus path: decodes each CPU bus cycle, issues a single SDRAM request on the ROM or RAM/VRAM port, latches the returned data for the CPU and drives `bus_cs`, `bus_busy` and `one_wait` into the DTACK generator directly downstream. One request per ASn assertion; nothing is issued for I/O or unmapped cycles, which complete with zero SDRAM wait.

---
 rtl/jtcps1_busreq_pkg.sv | 30 +++
 rtl/jtcps1_busreq_dec.sv | 26 ++
 rtl/jtcps1_main_busreq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/jtcps1_busreq_pkg.sv
// Shared types and constants for the CPS1 main-bus request front end.
// Consumed by the region decoder and the SDRAM request sequencer.
package jtcps1_busreq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    RG_ROM,
    RG_VRAM,
    RG_WRAM,
    RG_IO,
    RG_NONE
  } region_t;

  localparam logic [7:0]  VRAM_LO   = 8'h90;
  localparam logic [7:0]  VRAM_HI   = 8'h92;
  localparam logic [7:0]  WRAM_BASE = 8'hFF;
  localparam logic [11:0] IO_BASE   = 12'h800;
  localparam int          TOUT_DEF  = 255;

  function automatic logic is_ram(region_t r);
    return (r == RG_VRAM) || (r == RG_WRAM);
  endfunction

endpackage

// File: rtl/jtcps1_busreq_dec.sv
// Combinational 68000 address-to-region decoder.
// Shared with the sound-CPU bus path.
module jtcps1_busreq_dec
  import jtcps1_busreq_pkg::*;
(
  input  logic [23:1] a,
  output region_t     region
);

  always_comb begin
    region = RG_NONE;
    unique case (1'b1)
      a[23:22] == 2'b00:
        region = RG_ROM;
      a[23:16] >= VRAM_LO && a[23:16] <= VRAM_HI:
        region = RG_VRAM;
      a[23:16] == WRAM_BASE:
        region = RG_WRAM;
      a[23:12] == IO_BASE:
        region = RG_IO;
      default:
        region = RG_NONE;
    endcase
  end

endmodule

// File: rtl/jtcps1_main_busreq.sv
// Main 68000 bus front end: one SDRAM request per ASn cycle.
// JTCPS1_BUSREQ_TIMEOUT_EN adds a WAIT-state timeout abort.
module jtcps1_main_busreq
  import jtcps1_busreq_pkg::*;
`ifdef JTCPS1_BUSREQ_TIMEOUT_EN
#(
  parameter int TOUT_LIMIT = TOUT_DEF
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ASn,
  input  logic        RnW,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic [23:1] A,
  input  logic [15:0] cpu_dout,
  input  logic        rom_ok,
  input  logic        ram_ok,
  input  logic [15:0] rom_data,
  input  logic [15:0] ram_data,
  output logic        rom_cs,
  output logic [21:0] rom_addr,
  output logic        ram_cs,
  output logic [16:0] ram_addr,
  output logic        ram_we,
  output logic [1:0]  ram_dsn,
  output logic [15:0] ram_din,
  output logic        io_cs,
  output logic        bus_cs,
  output logic        bus_busy,
  output logic        one_wait,
  output logic [15:0] cpu_din,
  output logic        timeout_err
);

  state_t      st;
  region_t     region;
  region_t     rg;
  logic        asn_l;
  logic        rnw_l;
  logic        sel_ok;
  logic [15:0] sel_data;

  jtcps1_busreq_dec u_dec (
    .a      (A),
    .region (region)
  );

  assign io_cs    = !ASn && (region == RG_IO);
  assign sel_ok   = is_ram(rg) ? ram_ok : rom_ok;
  assign sel_data = is_ram(rg) ? ram_data : rom_data;

`ifdef JTCPS1_BUSREQ_TIMEOUT_EN
  logic [7:0] tout_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      rg       <= RG_NONE;
      asn_l    <= 1'b1;
      rnw_l    <= 1'b1;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      ram_cs   <= 1'b0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_dsn  <= 2'b11;
      ram_din  <= '0;
      bus_cs   <= 1'b0;
      bus_busy <= 1'b0;
      one_wait <= 1'b0;
      cpu_din  <= 16'hFFFF;
`ifdef JTCPS1_BUSREQ_TIMEOUT_EN
      tout_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      asn_l <= ASn;
      unique case (st)
        ST_IDLE: begin
          if (!ASn && asn_l) begin
            rg       <= region;
            rnw_l    <= RnW;
            one_wait <= is_ram(region) || (region == RG_IO);
            if (region == RG_ROM)
              rom_addr <= A[22:1];
            if (is_ram(region)) begin
              ram_addr <= (region == RG_WRAM) ?
                          {2'b11, A[15:1]} : A[17:1];
              ram_we   <= ~RnW;
              ram_dsn  <= {UDSn, LDSn};
              ram_din  <= cpu_dout;
            end
            if ((region == RG_ROM && RnW) || is_ram(region)) begin
              st <= ST_REQ;
            end else begin
              // no SDRAM traffic: zero-wait completion
              if (region == RG_NONE && RnW)
                cpu_din <= 16'hFFFF;
              st <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (ASn) begin
            one_wait <= 1'b0;
            st       <= ST_IDLE;
          end else begin
            rom_cs   <= (rg == RG_ROM);
            ram_cs   <= is_ram(rg);
            bus_cs   <= 1'b1;
            bus_busy <= 1'b1;
`ifdef JTCPS1_BUSREQ_TIMEOUT_EN
            tout_cnt <= '0;
`endif
            st       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ASn) begin
            rom_cs   <= 1'b0;
            ram_cs   <= 1'b0;
            bus_cs   <= 1'b0;
            bus_busy <= 1'b0;
            one_wait <= 1'b0;
            st       <= ST_IDLE;
          end else if (sel_ok) begin
            if (rnw_l)
              cpu_din <= sel_data;
            rom_cs   <= 1'b0;
            ram_cs   <= 1'b0;
            bus_busy <= 1'b0;
            st       <= ST_DONE;
          end
`ifdef JTCPS1_BUSREQ_TIMEOUT_EN
          else if (tout_cnt == 8'(TOUT_LIMIT - 1)) begin
            rom_cs      <= 1'b0;
            ram_cs      <= 1'b0;
            bus_busy    <= 1'b0;
            cpu_din     <= 16'hFFFF;
            timeout_err <= 1'b1;
            st          <= ST_DONE;
          end else begin
            tout_cnt <= tout_cnt + 8'd1;
          end
`endif
        end
        ST_DONE: begin
          if (ASn) begin
            bus_cs   <= 1'b0;
            one_wait <= 1'b0;
            st       <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
